// File: rtl/panel_pkg.sv
// -----------------------------------------------------------------------------
// panel_pkg
// Shared definitions for the status panel overlay: default timing constants,
// display FSM state encodings, and the error-code classifier.
// -----------------------------------------------------------------------------
package panel_pkg;

    // Defaults sized for a 25 MHz pixel clock: 10 ms debounce, 0.5 s flash half-period.
    localparam int STABLE_CYCLES_DEFAULT = 250000;
    localparam int FLASH_HALF_DEFAULT    = 12500000;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_BLINK   = 2'd1,
        ST_STEADY  = 2'd2,
        ST_ERROR   = 2'd3
    } disp_state_t;

    // A status code selects a row only when it is below the row count.
    function automatic logic is_error(input logic [7:0] code, input int rows);
        logic [31:0] c;
        c = {24'd0, code};
        return c >= unsigned'(rows);
    endfunction

endpackage

// File: rtl/status_debounce.sv
// -----------------------------------------------------------------------------
// status_debounce
// Filters relay chatter on the status code. A new code must hold for
// stable_cycles clocks before it is published on shown_status.
//
// Ports:
//   clk          in   pixel clock
//   reset        in   asynchronous, active-high
//   status       in   raw status code
//   shown_status out  debounced code currently published
//   shown_valid  out  a code has been accepted since reset
//   accept       out  1-cycle pulse, high in the cycle before shown_status updates
//   accept_code  out  code that is being accepted while accept is high
// -----------------------------------------------------------------------------
module status_debounce #(
    parameter int sw            = 3,
    parameter int stable_cycles = panel_pkg::STABLE_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [sw-1:0] status,
    output logic [sw-1:0] shown_status,
    output logic          shown_valid,
    output logic          accept,
    output logic [sw-1:0] accept_code
);

    localparam int CW = (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(stable_cycles - 1);

    logic [sw-1:0] cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [sw-1:0] shown_q, shown_d;
    logic          valid_q, valid_d;
    logic          changed;

    always_comb begin
        changed = (status != cand_q);
        // Accept is combinational so the display FSM can switch on the same
        // edge that publishes the new code.
        accept  = !changed && (cnt_q == CNT_LAST) &&
                  (!valid_q || (cand_q != shown_q));
        cand_d  = status;
        if (changed)
            cnt_d = '0;
        else if (cnt_q == CNT_LAST)
            cnt_d = cnt_q;              // saturate until the next change
        else
            cnt_d = cnt_q + 1'b1;
        shown_d = accept ? cand_q : shown_q;
        valid_d = valid_q | accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q  <= '0;
            cnt_q   <= '0;
            shown_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            shown_q <= shown_d;
            valid_q <= valid_d;
        end
    end

    assign shown_status = shown_q;
    assign shown_valid  = valid_q;
    assign accept_code  = cand_q;

endmodule

// File: rtl/status_panel_block.sv
// -----------------------------------------------------------------------------
// status_panel_block
// VGA status panel overlay: an N-row indicator grid at (x1, y1). The active
// row is lit green (blinking briefly after a change), an error code flashes
// the whole indicator column red. Row labels are drawn elsewhere.
//
// Ports:
//   clk             in   pixel clock
//   reset           in   asynchronous, active-high
//   status          in   status code; k < rows selects row k, otherwise error
//   x, y            in   current pixel column / row
//   on_panel_black  out  grid-line pixel (registered, 1-clock latency)
//   on_panel_green  out  active-row pixel (registered)
//   on_panel_red    out  error pixel (registered)
//   shown_status    out  debounced code being displayed
//   shown_valid     out  a debounced code has been accepted since reset
// -----------------------------------------------------------------------------
module status_panel_block
    import panel_pkg::*;
#(
    parameter int x1             = 0,
    parameter int y1             = 0,
    parameter int rows           = 3,
    parameter int sw             = 3,
    parameter int row_h          = 38,
    parameter int width          = 140,
    parameter int box_w          = 38,
    parameter int stable_cycles  = STABLE_CYCLES_DEFAULT,
    parameter int flash_half     = FLASH_HALF_DEFAULT,
    parameter int change_flashes = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [sw-1:0] status,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    output logic          on_panel_black,
    output logic          on_panel_green,
    output logic          on_panel_red,
    output logic [sw-1:0] shown_status,
    output logic          shown_valid
);

    localparam int FW = (flash_half > 1) ? $clog2(flash_half) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(flash_half - 1);
    localparam int BW = (2 * change_flashes + 1 > 2) ? $clog2(2 * change_flashes + 1) : 1;
    localparam logic [BW-1:0] BLINK_LOAD = BW'(2 * change_flashes);

    localparam logic signed [12:0] X_L   = 13'(x1);
    localparam logic signed [12:0] X_BOX = 13'(x1 + box_w);
    localparam logic signed [12:0] X_R   = 13'(x1 + width);
    localparam logic signed [12:0] BOX_L = 13'(x1 + 1);
    localparam logic signed [12:0] BOX_R = 13'(x1 + box_w - 1);
    localparam logic signed [12:0] Y_T   = 13'(y1);
    localparam logic signed [12:0] Y_B   = 13'(y1 + rows * row_h);

    logic          accept;
    logic [sw-1:0] accept_code;
    logic          accept_err;

    status_debounce #(
        .sw           (sw),
        .stable_cycles(stable_cycles)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .status      (status),
        .shown_status(shown_status),
        .shown_valid (shown_valid),
        .accept      (accept),
        .accept_code (accept_code)
    );

    assign accept_err = is_error(8'(accept_code), rows);

    // Flash timer: free-running, flash starts high out of reset.
    logic [FW-1:0] flash_cnt_q;
    logic          flash_q;
    logic          flash_wrap;

    assign flash_wrap = (flash_cnt_q == FLASH_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_cnt_q <= '0;
            flash_q     <= 1'b1;
        end else begin
            flash_cnt_q <= flash_wrap ? '0 : flash_cnt_q + 1'b1;
            if (flash_wrap)
                flash_q <= ~flash_q;
        end
    end

    // Display FSM: state register / next state / outputs.
    disp_state_t   state_q, state_d;
    logic [BW-1:0] blink_q;
    logic          green_en, red_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_UNKNOWN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_BLINK && blink_q == '0)
            state_d = ST_STEADY;
        // Accepts are only raised for a code that differs from the one shown,
        // so every valid accept is a row change and restarts the blink.
        if (accept)
            state_d = accept_err ? ST_ERROR : ST_BLINK;
    end

    always_comb begin
        green_en = 1'b0;
        red_en   = 1'b0;
        case (state_q)
            ST_BLINK:  green_en = flash_q;
            ST_STEADY: green_en = 1'b1;
            ST_ERROR:  red_en   = flash_q;
            default:   ;
        endcase
    end

    // Blink length counts flash toggles; a load on the same edge as a wrap wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blink_q <= '0;
        else if (accept && !accept_err)
            blink_q <= BLINK_LOAD;
        else if (state_q == ST_BLINK && flash_wrap && blink_q != '0)
            blink_q <= blink_q - 1'b1;
    end

    // Geometry (all ranges inclusive).
    logic signed [12:0] xs, ys;
    logic [rows:0]      hline;
    logic [rows-1:0]    row_hit;
    logic               vline, err_box, row_sel;

    assign xs = 13'({3'b000, x});
    assign ys = 13'({3'b000, y});

    for (genvar k = 0; k <= rows; k++) begin : g_hline
        localparam logic signed [12:0] YK = 13'(y1 + k * row_h);
        assign hline[k] = (ys == YK) && (xs >= X_L) && (xs <= X_R);
    end

    for (genvar k = 0; k < rows; k++) begin : g_row
        localparam logic signed [12:0] RT = 13'(y1 + k * row_h + 1);
        localparam logic signed [12:0] RB = 13'(y1 + (k + 1) * row_h - 1);
        assign row_hit[k] = (xs >= BOX_L) && (xs <= BOX_R) && (ys >= RT) && (ys <= RB);
    end

    assign vline   = ((xs == X_L) || (xs == X_BOX) || (xs == X_R)) &&
                     (ys >= Y_T) && (ys <= Y_B);
    assign err_box = (xs >= BOX_L) && (xs <= BOX_R) &&
                     (ys >= Y_T + 13'sd1) && (ys <= Y_B - 13'sd1);

    always_comb begin
        row_sel = 1'b0;
        for (int k = 0; k < rows; k++)
            if (shown_status == sw'(k))
                row_sel = row_hit[k];
    end

    // Registered pixel outputs.
    logic black_q, green_q, red_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            black_q <= 1'b0;
            green_q <= 1'b0;
            red_q   <= 1'b0;
        end else begin
            black_q <= (|hline) | vline;
            green_q <= green_en & row_sel;
            red_q   <= red_en & err_box;
        end
    end

    assign on_panel_black = black_q;
    assign on_panel_green = green_q;
    assign on_panel_red   = red_q;

endmodule

// File: tb/tb_status_panel_block.sv
module tb_status_panel_block;

    localparam int ROWS = 3;
    localparam int SW   = 2;
    localparam int SC   = 4;
    localparam int FH   = 8;
    localparam int CF   = 2;
    localparam int X1   = 10;
    localparam int Y1   = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] status;
    logic [9:0]    x, y;
    logic          on_panel_black, on_panel_green, on_panel_red;
    logic [SW-1:0] shown_status;
    logic          shown_valid;

    always #5 clk = ~clk;

    status_panel_block #(
        .x1(X1), .y1(Y1), .rows(ROWS), .sw(SW), .row_h(38), .width(140),
        .box_w(38), .stable_cycles(SC), .flash_half(FH), .change_flashes(CF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .status        (status),
        .x             (x),
        .y             (y),
        .on_panel_black(on_panel_black),
        .on_panel_green(on_panel_green),
        .on_panel_red  (on_panel_red),
        .shown_status  (shown_status),
        .shown_valid   (shown_valid)
    );

    int total = 0;
    int bad   = 0;
    int ncyc;   // clock edges since reset was released

    always @(posedge clk or posedge reset) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    typedef struct {
        string tag;
        logic  b;
        logic  g;
        logic  r;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flash level after n edges: starts high, toggles every FH edges.
    function automatic logic flash_m(input int n);
        return ((n / FH) % 2) == 0;
    endfunction

    // Green on the active row for a blink that started after a edges.
    function automatic logic green_blink(input int n, input int a);
        int t_last;
        if (n < a) return 1'b0;
        t_last = (a / FH + 1) * FH + (2 * CF - 1) * FH;
        return (n <= t_last) ? flash_m(n) : 1'b1;
    endfunction

    // Called right after a falling edge: drive pixel, queue expectation,
    // compare once the registered output appears after the next rising edge.
    task automatic pix(input int px, input int py, input logic eb, input logic eg,
                       input logic er, input string tag);
        exp_t e;
        x = 10'(px);
        y = 10'(py);
        sbq.push_back('{tag, eb, eg, er});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.tag, ".black"}, 32'(on_panel_black), 32'(e.b));
        chk({e.tag, ".green"}, 32'(on_panel_green), 32'(e.g));
        chk({e.tag, ".red"},   32'(on_panel_red),   32'(e.r));
    endtask

    task automatic npix(input int px, input int py, input logic eb, input logic eg,
                        input logic er, input string tag);
        @(negedge clk);
        pix(px, py, eb, eg, er, tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".black"}, 32'(on_panel_black), 32'd0);
        chk({tag, ".green"}, 32'(on_panel_green), 32'd0);
        chk({tag, ".red"},   32'(on_panel_red),   32'd0);
        chk({tag, ".shown"}, 32'(shown_status),   32'd0);
        chk({tag, ".valid"}, 32'(shown_valid),    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, a;
        reset  = 1'b1;
        status = 2'd1;
        x      = '0;
        y      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");

        // Row 1 accepted after SC clocks, blinks 2*CF toggles, then steady.
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n = ncyc;
            pix(20, 70, 1'b0, green_blink(n, 5), 1'b0, "blink_row1");
            chk("accept_valid", 32'(shown_valid), (ncyc >= 5) ? 32'd1 : 32'd0);
            chk("accept_code", 32'(shown_status), (ncyc >= 5) ? 32'd1 : 32'd0);
        end

        // Three-cycle glitch to 2 must not be shown nor restart the blink.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) status = 2'd2;
            if (i == 3) status = 2'd1;
            pix(20, 70, 1'b0, 1'b1, 1'b0, "glitch_row1");
            chk("glitch_shown", 32'(shown_status), 32'd1);
        end
        npix(20, 110, 1'b0, 1'b0, 1'b0, "glitch_row2");

        // Error code: red flashes on the error block, no green anywhere.
        @(negedge clk);
        status = 2'd3;
        m = ncyc;
        a = m + 5;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n = ncyc;
            if (i % 2 == 0)
                pix(20, 21, 1'b0, 1'b0, (n >= a) && flash_m(n), "err_top");
            else
                pix(20, 70, 1'b0, (n < a), (n >= a) && flash_m(n), "err_row1");
        end
        chk("err_shown", 32'(shown_status), 32'd3);

        // Settle on row 0 steady, then sweep geometry.
        @(negedge clk);
        status = 2'd0;
        repeat (50) @(negedge clk);
        chk("row0_shown", 32'(shown_status), 32'd0);
        npix(10,  20,  1'b1, 1'b0, 1'b0, "geo_corner_tl");
        npix(150, 134, 1'b1, 1'b0, 1'b0, "geo_corner_br");
        npix(48,  58,  1'b1, 1'b0, 1'b0, "geo_box_cross");
        npix(11,  21,  1'b0, 1'b1, 1'b0, "geo_inner");
        npix(10,  40,  1'b1, 1'b0, 1'b0, "geo_x10");
        npix(11,  40,  1'b0, 1'b1, 1'b0, "geo_x11");
        npix(47,  40,  1'b0, 1'b1, 1'b0, "geo_x47");
        npix(48,  40,  1'b1, 1'b0, 1'b0, "geo_x48");
        npix(20,  20,  1'b1, 1'b0, 1'b0, "geo_y20");
        npix(20,  57,  1'b0, 1'b1, 1'b0, "geo_y57");
        npix(20,  58,  1'b1, 1'b0, 1'b0, "geo_y58");
        npix(20,  70,  1'b0, 1'b0, 1'b0, "geo_row1_off");
        npix(100, 40,  1'b0, 1'b0, 1'b0, "geo_label_area");
        npix(151, 20,  1'b0, 1'b0, 1'b0, "geo_right_out");
        npix(10,  135, 1'b0, 1'b0, 1'b0, "geo_below");

        // Enter blink on row 2, then reset in the middle of it.
        @(negedge clk);
        status = 2'd2;
        m = ncyc;
        a = m + 5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n = ncyc;
            pix(20, 110, 1'b0, green_blink(n, a), 1'b0, "blink_row2");
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("reset_async");
        @(posedge clk);
        #1;
        chk_all_zero("reset_next");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n = ncyc;
            pix(20, 110, 1'b0, green_blink(n, 5), 1'b0, "rerun_row2");
            chk("rerun_valid", 32'(shown_valid), (ncyc >= 5) ? 32'd1 : 32'd0);
            chk("rerun_code", 32'(shown_status), (ncyc >= 5) ? 32'd2 : 32'd0);
        end

        // Single-cycle line pixel shows up exactly one clock later.
        npix(30, 30, 1'b0, 1'b0, 1'b0, "lat_before");
        npix(30, 20, 1'b1, 1'b0, 1'b0, "lat_line");
        npix(30, 30, 1'b0, 1'b0, 1'b0, "lat_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_panel_block.md
# status_panel_block

Parametrised status panel overlay for the VGA monitor: draws an N-row indicator grid at (x1, y1) and marks the active row green, or flashes the whole indicator column red on error. It extends the fixed three-row temperature panel in three ways:
- the row count is a parameter;
- the input status is debounced, so relay chatter does not flicker;
- a newly entered row blinks briefly before going steady.

It sits beside the text renderer in the display mux; row labels are drawn by the parent.

## Interface
- x1, 0: panel left edge (pixels)
- y1, 0: panel top edge (pixels)
- rows, 3: number of status rows, 1..7
- sw, 3: status code width; requires rows ≤ 2**sw − 1
- row_h, 38: row pitch (pixels)
- width, 140: panel width (pixels)
- box_w, 38: indicator column width (pixels)
- stable_cycles, 250000: clocks a new code must hold before it is shown
- flash_half, 12500000: clocks per flash half-period
- change_flashes, 3: blink periods shown after a row change

Ports:
- clk  in  1: pixel clock
- reset  in  1: asynchronous, active-high
- status  in  sw: code k < rows selects row k; any code ≥ rows means error
- x  in  10: current pixel column
- y  in  10: current pixel row
- on_panel_black  out  1: grid-line pixel, registered
- on_panel_green  out  1: active-row pixel, registered
- on_panel_red  out  1: error pixel, registered
- shown_status  out  sw: debounced code currently displayed
- shown_valid  out  1: a debounced code has been accepted since reset

## Operation
- **Geometry.** All ranges are inclusive.
  - Horizontal lines at y = y1 + k·row_h for k = 0..rows, spanning x1..x1+width.
  - Vertical lines at x = x1, x1+box_w and x1+width, spanning y1..y1+rows·row_h.
  - Row-k block: x1+1..x1+box_w−1, y1+k·row_h+1..y1+(k+1)·row_h−1.
  - Error block: x1+1..x1+box_w−1, y1+1..y1+rows·row_h−1.
- **Debounce.**
  - A candidate register and a stable counter track `status`.
  - Any change in `status` reloads the candidate and clears the counter.
  - When the counter reaches stable_cycles−1 with the candidate unchanged:
    - shown_status ← candidate and shown_valid ← 1;
    - the counter saturates until the next change.
  - A candidate equal to shown_status causes no update event.
- **Flash timer.** A free-running counter 0..flash_half−1 toggles `flash` on wrap.
- **Display FSM.**
  - UNKNOWN (reset state): no green, no red. Go to BLINK or ERROR on the first accept.
  - BLINK: green on row shown_status only while flash = 1.
    - Loads blink_cnt = 2·change_flashes on entry and decrements on each flash toggle.
    - At 0, go to STEADY.
  - STEADY: green on row shown_status continuously.
  - ERROR: red on the error block while flash = 1. No green.
  - From any non-UNKNOWN state:
    - an accept of a valid code different from the previous one goes to BLINK;
    - an accept of an error code goes to ERROR.
  - ERROR → valid code always enters BLINK.
- The black, green and red masks are mutually unrelated; the parent applies the priority red > green > black.

## Timing
- Reset values:
  - outputs: all on_* = 0, shown_status = 0, shown_valid = 0;
  - internals: flash = 1, flash counter = 0, stable counter = 0, state UNKNOWN.
- Pixel outputs have 1-clock latency from x/y: outputs at cycle n+1 correspond to x/y at cycle n.
- A status change at cycle t is shown at cycle t+stable_cycles. The FSM state updates in the same cycle as shown_status.
- A change that reverts before stable_cycles is never shown.
- Reset asserted mid-blink or mid-error returns everything to reset values on the same edge.
- Blink duration is measured in flash toggles, not clocks, so the first blink period may be partial.
- Flash-counter wrap and an accept in the same cycle: both take effect. blink_cnt loads without also decrementing.

## Structure
- Shared package/header `panel_pkg`:
  - flash_half and stable_cycles defaults;
  - FSM state encodings (UNKNOWN, BLINK, STEADY, ERROR);
  - the is_error(code, rows) function.
- Sub-module `status_debounce`, parameters sw and stable_cycles.
  - Inputs: clk, reset, status.
  - Outputs: shown_status, shown_valid, a 1-cycle `accept` pulse.
- Geometry is generated with a row loop and compares inline; the FSM and flash timer live in the top module.

## Test plan
Use rows=3, sw=2, stable_cycles=4, flash_half=8, change_flashes=2, x1=10, y1=20.
- Reset, then status=1 held → shown_status=1 at cycle 4 and shown_valid=1; green at (20, 70) only while flash=1 for 4 toggles (32 clocks), then steady.
- status=1 with a 3-cycle glitch to 2 → shown_status stays 1, no BLINK re-entry.
- status=3 (error) held → after 4 clocks red at (20, 21) toggles every 8 clocks; on_panel_green=0 everywhere.
- Geometry sweep at idle:
  - black at (10, 20), (150, 134), (48, 58);
  - not black at (11, 21);
  - green box bounds exactly x 11..47 per row.
- Reset asserted during BLINK → next cycle all outputs 0 and state UNKNOWN; with status held, shown_valid reasserts after 4 clocks.
- Pixel latency: drive x/y onto a line pixel for a single cycle → on_panel_black high exactly one cycle later.
